// File: rtl/jtag_mem_bridge.sv
// jtag_mem_bridge: JTAG virtual-DR bridge onto one of CHANNELS memory ports.
// Serves the IDENT, read/write address, read/write data, channel select and
// status data registers behind a jtag_tap. Reads use a req/valid handshake
// with arbitrary latency. Writes are a single-cycle strobe.
// Optional feature: define JTAG_MEM_AUTOINC_EN to enable address
// auto-increment. An IRDATA update then prefetches the next word, and each
// write strobe advances the write address.
module jtag_mem_bridge #(
    parameter int DR_LENGTH = 32,
    parameter int ADDR_W    = 10,
    parameter int CHANNELS  = 4,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter logic [DR_LENGTH-1:0] IDENT = 'h4A544731,
    parameter int IR_LENGTH = 4,
    parameter logic [IR_LENGTH-1:0] IBYPASS = 'hF,
    parameter logic [IR_LENGTH-1:0] IIDENT  = 'h1,
    parameter logic [IR_LENGTH-1:0] IRADDR  = 'h2,
    parameter logic [IR_LENGTH-1:0] IWADDR  = 'h3,
    parameter logic [IR_LENGTH-1:0] IRDATA  = 'h4,
    parameter logic [IR_LENGTH-1:0] IWDATA  = 'h5,
    parameter logic [IR_LENGTH-1:0] ICHAN   = 'h6,
    parameter logic [IR_LENGTH-1:0] ISTAT   = 'h7
) (
    input  logic                 tck,
    input  logic                 rst,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic [IR_LENGTH-1:0] ir,
    input  logic                 capture_dr,
    input  logic                 shift_dr,
    input  logic                 update_dr,
    output logic [CH_W-1:0]      mem_chan,
    output logic [ADDR_W-1:0]    mem_raddr,
    output logic                 mem_rd_req,
    input  logic                 mem_rvalid,
    input  logic [DR_LENGTH-1:0] mem_rdata,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [DR_LENGTH-1:0] mem_wdata,
    output logic                 mem_we
);

    typedef enum logic {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } rd_state_e;

    rd_state_e             state_q, state_d;
    logic [DR_LENGTH-1:0]  sr_q, sr_d;
    logic [DR_LENGTH-1:0]  wdata_q, wdata_d;
    logic [DR_LENGTH-1:0]  rdata_hold_q, rdata_hold_d;
    logic [ADDR_W-1:0]     raddr_q, raddr_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic                  bypass_q, bypass_d;
    logic                  overrun_q, overrun_d;
    logic                  rd_req_q, rd_req_d;
    logic                  we_q, we_d;

    logic                  rd_pending;
    logic                  issue;        // a read is requested this cycle
    logic                  stat_clear;   // ISTAT captured: clear overrun
    logic                  stale_read;   // IRDATA captured while a read is in flight
    logic [DR_LENGTH-1:0]  stat_word;

    assign rd_pending = (state_q == R_WAIT);

    assign tdo        = (ir == IBYPASS) ? bypass_q : sr_q[0];
    assign mem_chan   = chan_q;
    assign mem_raddr  = raddr_q;
    assign mem_rd_req = rd_req_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;

    // Status word: channel in the low bits, then rd_pending, then overrun.
    always_comb begin
        stat_word             = '0;
        stat_word[CH_W-1:0]   = chan_q;
        stat_word[CH_W]       = rd_pending;
        stat_word[CH_W+1]     = overrun_q;
    end

    // DR datapath: capture, shift and update of the data registers.
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sr_d       = sr_q;
        bypass_d   = tdi;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        chan_d     = chan_q;
        we_d       = 1'b0;
        issue      = 1'b0;
        stat_clear = 1'b0;
        stale_read = 1'b0;

`ifdef JTAG_MEM_AUTOINC_EN
        // Advance the write address as the strobe drops.
        if (we_q) begin
            waddr_d = waddr_q + ADDR_W'(1);
        end
`endif

        if (capture_dr) begin
            case (ir)
                IIDENT: sr_d = IDENT;
                IRADDR: sr_d = DR_LENGTH'(raddr_q);
                IWADDR: sr_d = DR_LENGTH'(waddr_q);
                IWDATA: sr_d = wdata_q;
                ICHAN:  sr_d = DR_LENGTH'(chan_q);
                IRDATA: begin
                    sr_d       = rdata_hold_q;
                    stale_read = rd_pending;
                end
                ISTAT: begin
                    sr_d       = stat_word;
                    stat_clear = 1'b1;
                end
                default: ;
            endcase
        end else if (shift_dr) begin
            sr_d = {tdi, sr_q[DR_LENGTH-1:1]};
        end

        if (update_dr) begin
            case (ir)
                IRADDR: begin
                    raddr_d = sr_q[ADDR_W-1:0];
                    issue   = 1'b1;
                end
                IWADDR: waddr_d = sr_q[ADDR_W-1:0];
                IWDATA: begin
                    wdata_d = sr_q;
                    we_d    = 1'b1;
                end
                ICHAN: begin
                    // Out-of-range channel numbers are ignored.
                    if (sr_q < DR_LENGTH'(CHANNELS)) begin
                        chan_d = sr_q[CH_W-1:0];
                    end
                end
`ifdef JTAG_MEM_AUTOINC_EN
                IRDATA: begin
                    raddr_d = raddr_q + ADDR_W'(1);
                    issue   = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Read FSM: issue request, wait for valid, latch data; track overrun.
    always_comb begin
        state_d      = state_q;
        rd_req_d     = 1'b0;
        rdata_hold_d = rdata_hold_q;
        overrun_d    = overrun_q;

        if (stat_clear) begin
            overrun_d = 1'b0;
        end
        if (stale_read) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            R_IDLE: begin
                if (issue) begin
                    state_d  = R_WAIT;
                    rd_req_d = 1'b1;
                end
            end
            R_WAIT: begin
                if (mem_rvalid) begin
                    rdata_hold_d = mem_rdata;
                    state_d      = R_IDLE;
                    // A new read issued as the old one completes is accepted.
                    if (issue) begin
                        state_d  = R_WAIT;
                        rd_req_d = 1'b1;
                    end
                end else if (issue) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tck) begin
        if (rst) begin
            state_q      <= R_IDLE;
            sr_q         <= '0;
            bypass_q     <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            rdata_hold_q <= '0;
            chan_q       <= '0;
            overrun_q    <= 1'b0;
            rd_req_q     <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bypass_q     <= bypass_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            rdata_hold_q <= rdata_hold_d;
            chan_q       <= chan_d;
            overrun_q    <= overrun_d;
            rd_req_q     <= rd_req_d;
            we_q         <= we_d;
        end
    end

endmodule
